// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: IO offsets,
// STATUS bit positions and transmitter FSM encodings.
package uart_tx_io_pkg;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // STATUS reports the FIFO fill level in a nibble, clamped at 15.
    function automatic logic [3:0] sat_count(input int unsigned n);
        return (n > 15) ? 4'hF : 4'(n);
    endfunction

endpackage

// File: rtl/uart_tx_io_if.sv
// IO-page bus between the core's data port and the UART: single-cycle
// strobes, registered read data.
interface uart_tx_io_if;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata;
    logic        io_wstrb;
    logic        io_rstrb;
    logic [31:0] io_rdata;

    modport master (output io_addr, io_wdata, io_wstrb, io_rstrb, input io_rdata);
    modport slave  (input io_addr, io_wdata, io_wstrb, io_rstrb, output io_rdata);
endinterface

// File: rtl/uart_tx_io_sync_fifo.sv
// First-word-fall-through FIFO; pointers wrap modulo DEPTH, occupancy
// tracked in a separate count register.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             push_fire, pop_fire;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    // A push into a full FIFO is still taken when a pop frees a slot this cycle.
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    always_comb begin
        count_next = count_reg;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register decode, sticky
// overflow flag, TX FIFO and the serializer FSM with its baud counter.
module uart_tx_io
    import uart_tx_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_io_if.slave  bus,
    output logic         txd,
    output logic         tx_busy
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_t      state_reg, state_next;
    logic [BW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [7:0]     shift_reg, shift_next;
    logic           txd_reg, txd_next;
    logic           busy_reg, busy_next;
    logic           overflow_reg, overflow_next;
    logic [31:0]    rdata_reg, rdata_next;
    logic [31:0]    status;

    logic           fifo_full, fifo_empty, pop;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           wr_data, rd_status, push_fire, overflow_set, bit_done;

    wire unused_bus_bits = &{1'b0, bus.io_wdata[31:8], bus.io_addr[1:0]};

    assign wr_data      = bus.io_wstrb && (bus.io_addr[3:2] == UART_DATA[3:2]);
    assign rd_status    = bus.io_rstrb && (bus.io_addr[3:2] == UART_STATUS[3:2]);
    assign push_fire    = wr_data && (!fifo_full || pop);
    assign overflow_set = wr_data && fifo_full && !pop;
    assign bit_done     = (baud_reg == '0);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (pop),
        .din   (bus.io_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
            overflow_reg <= overflow_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next   = S_START;
                    baud_next    = BAUD_MAX;
                    bit_idx_next = '0;
                    shift_next   = fifo_dout;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next   = S_DATA;
                    baud_next    = BAUD_MAX;
                    bit_idx_next = '0;
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_next = BAUD_MAX;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        state_next   = S_START;
                        baud_next    = BAUD_MAX;
                        bit_idx_next = '0;
                        shift_next   = fifo_dout;
                    end else begin
                        state_next = S_IDLE;
                        baud_next  = '0;
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line and busy outputs are derived from next-state values so they are
    // registered in lock-step with the FSM.
    always_comb begin
        pop = !fifo_empty && ((state_reg == S_IDLE) || (state_reg == S_STOP && bit_done));
        case (state_next)
            S_START: txd_next = 1'b0;
            S_DATA:  txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
        busy_next = (state_next != S_IDLE) || push_fire;
    end

    always_comb begin
        status                                 = '0;
        status[ST_FULL]                        = fifo_full;
        status[ST_EMPTY]                       = fifo_empty;
        status[ST_ACTIVE]                      = (state_reg != S_IDLE);
        status[ST_OVERFLOW]                    = overflow_reg;
        status[ST_COUNT_LSB+3:ST_COUNT_LSB]    = sat_count(32'(fifo_count));

        rdata_next = rdata_reg;
        if (bus.io_rstrb) begin
            rdata_next = rd_status ? status : 32'h0;
        end

        // A fresh overflow in the same cycle as a STATUS read wins over the clear.
        overflow_next = overflow_reg;
        if (overflow_set) begin
            overflow_next = 1'b1;
        end else if (rd_status) begin
            overflow_next = 1'b0;
        end
    end

    assign txd         = txd_reg;
    assign tx_busy     = busy_reg;
    assign bus.io_rdata = rdata_reg;

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io (CLKS_PER_BIT=4, FIFO_DEPTH=4): a monitor
// logs txd/tx_busy per cycle, the linear sequence checks frames and registers.
module tb_uart_tx_io;

    localparam int CPB  = 4;
    localparam int HIST = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic txd, tx_busy;

    uart_tx_io_if bus();

    uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic txd_hist  [HIST];
    logic busy_hist [HIST];
    always @(negedge clk) begin
        if (cyc < HIST) begin
            txd_hist[cyc]  = txd;
            busy_hist[cyc] = tx_busy;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, output int n);
        n = cyc;
        bus.io_addr  = a;
        bus.io_wdata = {24'hC3C3C3, d};
        bus.io_wstrb = 1'b1;
        $display("cycle %0d: write addr=0x%0h data=0x%02h", n, a, d);
        @(posedge clk);
        #1;
        bus.io_wstrb = 1'b0;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
        $display("cycle %0d: read addr=0x%0h", cyc, a);
        bus.io_addr  = a;
        bus.io_rstrb = 1'b1;
        @(posedge clk);
        #1;
        bus.io_rstrb = 1'b0;
        @(negedge clk);
        check(tag, {32'h0, bus.io_rdata}, {32'h0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int start, input logic [7:0] b, input string tag);
        logic [63:0] txd_obs, txd_exp, busy_obs, busy_exp;
        logic [9:0]  fr;
        wait_until(start + 10 * CPB + 1);
        fr = {1'b1, b, 1'b0};
        txd_obs = '0; txd_exp = '0; busy_obs = '0; busy_exp = '0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                txd_exp[k * CPB + c]  = fr[k];
                txd_obs[k * CPB + c]  = txd_hist[start + k * CPB + c];
                busy_exp[k * CPB + c] = 1'b1;
                busy_obs[k * CPB + c] = busy_hist[start + k * CPB + c];
            end
        end
        $display("frame %s: start cycle %0d byte=0x%02h", tag, start, b);
        check({tag, "_txd"}, txd_obs, txd_exp);
        check({tag, "_busy"}, busy_obs, busy_exp);
    endtask

    task automatic check_idle(input int start, input int n, input string tag);
        int lows, busys;
        wait_until(start + n + 1);
        lows = 0; busys = 0;
        for (int i = 0; i < n; i++) begin
            if (txd_hist[start + i] !== 1'b1) lows++;
            if (busy_hist[start + i] !== 1'b0) busys++;
        end
        $display("idle %s: cycles %0d..%0d", tag, start, start + n - 1);
        check({tag, "_txd_low_cycles"}, 64'(lows), 64'd0);
        check({tag, "_busy_cycles"}, 64'(busys), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int n, o, m, k, b0;
        bus.io_addr  = '0;
        bus.io_wdata = '0;
        bus.io_wstrb = 1'b0;
        bus.io_rstrb = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", 64'(txd), 64'd1);
        check("reset_busy", 64'(tx_busy), 64'd0);
        check("reset_rdata", {32'h0, bus.io_rdata}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Register decode with an empty FIFO
        read_check(4'h4, 32'h0000_0002, "status_empty");
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", {32'h0, bus.io_rdata}, 64'h2);
        read_check(4'h8, 32'h0, "read_unmapped");
        read_check(4'h6, 32'h0000_0002, "status_low_bits_ignored");
        read_check(4'h0, 32'h0, "read_data_reg");
        wr(4'h8, 8'hFF, n);
        @(negedge clk);
        check("unmapped_write_busy", 64'(tx_busy), 64'd0);
        @(posedge clk);
        #1;
        read_check(4'h4, 32'h0000_0002, "status_after_unmapped_write");

        // Single byte: txd falls two cycles after the strobe
        wr(4'h0, 8'hA5, n);
        read_check(4'h4, 32'h0000_0010, "status_one_queued");
        wait_until(n + 2);
        check("single_pre_start_txd", 64'(txd_hist[n + 1]), 64'd1);
        check("single_pre_start_busy", 64'(busy_hist[n + 1]), 64'd1);
        check_frame(n + 2, 8'hA5, "single");
        check_idle(n + 2 + 10 * CPB, 4, "single_end");

        // Back-to-back: three contiguous frames
        wr(4'h0, 8'h01, b0);
        wr(4'h0, 8'h02, n);
        wr(4'h3, 8'h03, n);
        check_frame(b0 + 2, 8'h01, "b2b0");
        check_frame(b0 + 2 + 10 * CPB, 8'h02, "b2b1");
        check_frame(b0 + 2 + 20 * CPB, 8'h03, "b2b2");
        check_idle(b0 + 2 + 30 * CPB, 4, "b2b_end");

        // Overflow: sixth consecutive write is dropped
        o = cyc;
        for (int i = 0; i < 6; i++) begin
            wr(4'h0, 8'(8'h11 + i), n);
        end
        read_check(4'h4, 32'h0000_004D, "status_overflow");
        read_check(4'h4, 32'h0000_0045, "status_overflow_cleared");
        for (int i = 0; i < 5; i++) begin
            check_frame(o + 2 + i * 10 * CPB, 8'(8'h11 + i), $sformatf("ovf%0d", i));
        end
        check_idle(o + 2 + 50 * CPB, 10 * CPB, "ovf_dropped");

        // Full FIFO with a write on the cycle the FSM pops
        m = cyc;
        for (int i = 0; i < 5; i++) begin
            wr(4'h0, 8'(8'h21 + i), n);
        end
        read_check(4'h4, 32'h0000_0045, "status_full");
        wait_until(m + 1 + 10 * CPB);
        $display("cycle %0d: write+read addr=0x0 data=0x26", cyc);
        bus.io_addr  = 4'h0;
        bus.io_wdata = 32'h0000_0026;
        bus.io_wstrb = 1'b1;
        bus.io_rstrb = 1'b1;
        @(posedge clk);
        #1;
        bus.io_wstrb = 1'b0;
        bus.io_rstrb = 1'b0;
        check("simul_read_data_reg", {32'h0, bus.io_rdata}, 64'h0);
        read_check(4'h4, 32'h0000_0045, "status_full_pop_push");
        for (int i = 0; i < 6; i++) begin
            check_frame(m + 2 + i * 10 * CPB, 8'(8'h21 + i), $sformatf("fullpop%0d", i));
        end
        check_idle(m + 2 + 60 * CPB, 4, "fullpop_end");

        // Reset during DATA bit 3 discards the frame and the queue
        wr(4'h0, 8'h00, k);
        wr(4'h0, 8'h00, n);
        wait_until(k + 2 + 4 * CPB);
        @(negedge clk);
        check("midframe_txd_before_reset", 64'(txd), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midframe_reset_txd", 64'(txd), 64'd1);
        check("midframe_reset_busy", 64'(tx_busy), 64'd0);
        @(posedge clk);
        #1;
        read_check(4'h4, 32'h0000_0002, "status_after_reset");
        check_idle(k + 3 + 4 * CPB, 15 * CPB, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_io.md
# uart_tx_io

Memory-mapped 8N1 UART transmitter that sits downstream of the processor's data-bus port and drives the SOC `TXD` pin. Programs running on the core write bytes to a DATA register, which queues them in a small FIFO. A status register lets software poll for space. The bus side matches the single-cycle-strobe, registered-read convention of the instruction/data memory, so the SOC address decoder can route an IO page to this block unchanged.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: clk cycles per UART bit (12 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `io_addr`  in  4  byte offset within the IO page; bits [1:0] ignored.
- `io_wdata`  in  32  write data; only [7:0] used.
- `io_wstrb`  in  1  one-cycle write strobe.
- `io_rstrb`  in  1  one-cycle read strobe.
- `io_rdata`  out  32  registered read data.
- `txd`  out  1  serial output, idle high.
- `tx_busy`  out  1  high when the FIFO is non-empty or a frame is in flight.

## Operation
Register map:
- 0x0 DATA (write-only): pushes `io_wdata[7:0]`. Reads return 0.
- 0x4 STATUS (read-only):
  - bit0 full; bit1 empty; bit2 tx_active (FSM not IDLE); bit3 overflow (sticky).
  - bits[7:4] FIFO count, saturating at 15.
  - all other bits 0.
- Any other offset: writes are ignored, reads return 0.

FIFO push and pop:
- Push is judged on pre-cycle state.
- If full and no pop in the same cycle, the byte is dropped and overflow is set.
- If full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- Empty with push and pop in the same cycle cannot occur, because a pop requires pre-cycle non-empty.
- A STATUS read clears overflow one cycle after the strobe. The returned value still shows overflow=1. If a new overflow happens in that same cycle, set wins.

Transmitter FSM: IDLE → START → DATA → STOP.
- IDLE: `txd`=1. If the FIFO is non-empty, pop into an 8-bit shift register and go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles.
  - On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (zero idle gap).
  - Otherwise go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It reloads to `CLKS_PER_BIT-1` on every bit start and decrements to 0. Count 0 marks the last cycle of a bit.

## Timing
- Reset values:
  - `txd`=1, `tx_busy`=0, `io_rdata`=0.
  - FSM in IDLE, FIFO empty, overflow=0, counters 0.
- Reset mid-frame: the frame is truncated and `txd`=1 from the next cycle. Queued bytes are discarded.
- Read latency: `io_rdata` is valid the cycle after `io_rstrb` and holds its value until the next `io_rstrb`.
- Write-to-line latency: with `io_wstrb` at cycle N into an idle, empty block:
  - the byte is in the FIFO at N+1;
  - the FSM pops at N+1;
  - `txd` falls at N+2.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- `tx_busy` is registered with `txd` (its value follows the same cycle's FIFO/FSM state). It falls in the cycle the FSM returns to IDLE with the FIFO empty.
- Simultaneous `io_wstrb` and `io_rstrb`: both are serviced. A read of STATUS reflects pre-cycle state.

## Structure
- Shared defines header (alongside the existing opcode/funct3 defines):
  - IO register offsets `UART_DATA`=0x0 and `UART_STATUS`=0x4;
  - STATUS bit positions;
  - FSM state encodings (2 bits).
- Sub-module `sync_fifo` with parameters WIDTH and DEPTH:
  - ports: push, pop, din, dout, full, empty, count;
  - first-word-fall-through; wraps pointers modulo DEPTH with an extra count register.
- Top level holds register decode, the overflow flag, the FSM, the baud counter and the shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Single byte: write 0xA5 to 0x0 at cycle N. `txd` falls at N+2. Sampled bits are 1,0,1,0,0,1,0,1 then stop=1. Frame is 40 cycles and `tx_busy` drops at frame end.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles. Three contiguous frames totalling 120 cycles with no idle high between stop and start.
- Overflow: six writes on consecutive cycles (first pop at N+1).
  - Bytes 1–5 are accepted and byte 6 is dropped.
  - STATUS read returns bit0=1, bit3=1, count=4.
  - A second read returns bit3=0.
- Status empty: after reset, read 0x4 → `io_rdata`=0x00000002 next cycle. Read 0x8 → 0.
- Reset mid-frame: assert reset during DATA bit 3. `txd`=1 next cycle, STATUS reads 0x2, and no further frame is emitted.
- Full with simultaneous pop: fill to 4 and write again on the cycle the FSM pops. The byte is accepted, count stays 4 and overflow stays 0.
